// File: rtl/phy_rx_aligner_pkg.sv
// Shared constants and state encoding for the lane receive aligner.
// PHY_RX_SKIP_EN makes SKP_BYTE behave like COM while active.
package phy_rx_aligner_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COM_BYTE_DEF = 8'hBC;
  localparam logic [BYTE_W-1:0] SKP_BYTE     = 8'h1C;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

endpackage

// File: rtl/phy_rx_shifter.sv
// MSB-first serial shift register producing the candidate byte
// that includes the bit currently on data_in.
module phy_rx_shifter
  import phy_rx_aligner_pkg::*;
(
  input  logic              clk32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] cand
);

  logic [BYTE_W-1:0] sr;

  assign cand = {sr[BYTE_W-2:0], data_in};

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= cand;
  end

endmodule

// File: rtl/phy_rx_aligner.sv
// Lane receive aligner: COM hunt, lock qualification, byte delivery.
// Build option PHY_RX_SKIP_EN drops SKP bytes once locked.
module phy_rx_aligner
  import phy_rx_aligner_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM_BYTE   = COM_BYTE_DEF,
  parameter int                LOCK_COUNT = 4
) (
  input  logic              clk32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] out,
  output logic              valid_out,
  output logic              active
);

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [3:0]        com_cnt;
  logic [3:0]        com_nxt;
  logic [BYTE_W-1:0] b;
  logic              is_com;
  logic              is_idle;
  logic              boundary;

  phy_rx_shifter u_shifter (
    .clk32f  (clk32f),
    .reset   (reset),
    .data_in (data_in),
    .cand    (b)
  );

  assign is_com   = (b == COM_BYTE);
  assign boundary = (bit_cnt == 3'd7);
  assign com_nxt  = com_cnt + 4'd1;

`ifdef PHY_RX_SKIP_EN
  assign is_idle = is_com || (b == SKP_BYTE);
`else
  assign is_idle = is_com;
`endif

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      bit_cnt   <= 3'd0;
      com_cnt   <= 4'd0;
      out       <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      case (state)
        LOCKING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              com_cnt <= com_nxt;
              if (com_nxt == 4'(LOCK_COUNT)) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // misaligned or broken run: start over from the next bit
              state   <= HUNT;
              com_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_idle) begin
              valid_out <= 1'b0;
            end else begin
              out       <= b;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          out       <= '0;
          valid_out <= 1'b0;
          active    <= 1'b0;
          if (is_com) begin
            state   <= LOCKING;
            bit_cnt <= 3'd0;
            com_cnt <= 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_aligner.sv
// Directed bench for phy_rx_aligner: lock, data delivery, relock.
// Expects SKP handling according to PHY_RX_SKIP_EN.
module tb_phy_rx_aligner;

  logic       clk32f = 1'b0;
  logic       reset  = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] out;
  logic       valid_out;
  logic       active;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] p_out = 8'h00;
  logic       p_val = 1'b0;
  logic       p_act = 1'b0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] e_out;
    logic       e_val;
    logic       e_act;
  } vec_t;

  vec_t tbl[12];

  phy_rx_aligner dut (
    .clk32f    (clk32f),
    .reset     (reset),
    .data_in   (data_in),
    .out       (out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk32f = ~clk32f;

  task automatic chk(input string nm, input logic [9:0] exp);
    logic [9:0] got;
    got = {out, valid_out, active};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got out/valid/active=%h/%b/%b expected %h/%b/%b",
               nm, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk32f);
    #1;
  endtask

  task automatic apply_byte(input string nm, input logic [7:0] din,
                            input logic [7:0] eo, input logic ev,
                            input logic ea);
    for (int i = 7; i >= 0; i--) begin
      send_bit(din[i]);
      if (i != 0) chk({nm, "_hold"}, {p_out, p_val, p_act});
      else        chk(nm, {eo, ev, ea});
    end
    p_out = eo;
    p_val = ev;
    p_act = ea;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_immediate", 10'h000);
    repeat (2) @(posedge clk32f);
    #1;
    chk("reset_held", 10'h000);
    reset   = 1'b0;
    data_in = 1'b0;
    p_out   = 8'h00;
    p_val   = 1'b0;
    p_act   = 1'b0;
  endtask

  task automatic lock4(input string nm);
    for (int k = 0; k < 4; k++)
      apply_byte(nm, 8'hBC, 8'h00, 1'b0, (k == 3));
  endtask

  initial begin
    tbl[0]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{8'hBC, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{8'hA5, 8'hA5, 1'b1, 1'b1};
    tbl[5]  = '{8'h3C, 8'h3C, 1'b1, 1'b1};
    tbl[6]  = '{8'hBC, 8'h3C, 1'b0, 1'b1};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b1, 1'b1};
`ifdef PHY_RX_SKIP_EN
    tbl[8]  = '{8'h1C, 8'hFF, 1'b0, 1'b1};
`else
    tbl[8]  = '{8'h1C, 8'h1C, 1'b1, 1'b1};
`endif
    tbl[9]  = '{8'h5A, 8'h5A, 1'b1, 1'b1};
    // COM straddling two bytes at offset 4 must not realign
    tbl[10] = '{8'h0B, 8'h0B, 1'b1, 1'b1};
    tbl[11] = '{8'hC0, 8'hC0, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0);
      chk("prefix", 10'h000);
    end
    for (int i = 0; i < 12; i++)
      apply_byte($sformatf("vec%0d", i), tbl[i].din,
                 tbl[i].e_out, tbl[i].e_val, tbl[i].e_act);

    // reset between bits 3 and 4 of a data byte
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset();
    lock4("relock");
    apply_byte("after_relock", 8'h77, 8'h77, 1'b1, 1'b1);

    // broken COM run: three COMs, a data byte, then a full run
    do_reset();
    for (int k = 0; k < 3; k++)
      apply_byte("partial", 8'hBC, 8'h00, 1'b0, 1'b0);
    apply_byte("break", 8'h00, 8'h00, 1'b0, 1'b0);
    lock4("rerun");
    apply_byte("rerun_data", 8'h42, 8'h42, 1'b1, 1'b1);

    // no false lock from an embedded COM-like pattern
    do_reset();
    apply_byte("nolock_5e", 8'h5E, 8'h00, 1'b0, 1'b0);
    apply_byte("nolock_00", 8'h00, 8'h00, 1'b0, 1'b0);
    apply_byte("nolock_00b", 8'h00, 8'h00, 1'b0, 1'b0);
    lock4("clean");
    apply_byte("clean_data", 8'h81, 8'h81, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
